// File: rtl/io_device_regs.sv
// Keyboard/display device registers: keyboard byte FIFO (KBDR/KBSR), display
// output handshake (DDR/DSR) and the read mux that feeds the MDR.
module io_device_regs #(
  parameter int unsigned KBD_DEPTH  = 4,
  parameter int unsigned DISP_DELAY = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic [15:0] MDR_OUT,
  input  logic        LD_KBSR,
  input  logic        LD_DDR,
  input  logic        LD_DSR,
  input  logic [1:0]  INMUX_SEL,
  input  logic        LD_MDR,
  input  logic [15:0] MEM_OUT,
  input  logic        KBD_VALID,
  input  logic [7:0]  KBD_DATA,
  output logic        KBD_READY,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_DATA,
  input  logic        DISP_READY,
  output logic [15:0] IN_MUX_OUT,
  output logic        KB_INTR,
  output logic        DISP_INTR
);

  localparam int unsigned PTR_W = (KBD_DEPTH > 2) ? $clog2(KBD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DLY_W = (DISP_DELAY > 1) ? $clog2(DISP_DELAY + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_e;

  logic [7:0]       fifo_q [KBD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             kbsr_ie_q, kbsr_ie_d;
  logic             dsr_ie_q, dsr_ie_d;
  logic             dsr_rdy_q, dsr_rdy_d;
  logic [15:0]      ddr_q, ddr_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic             disp_valid_q, disp_valid_d;
  state_e           state_q, state_d;

  logic fifo_empty, fifo_full, push, pop;
  logic [15:0] kbdr, kbsr, dsr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(KBD_DEPTH));
  // Readiness depends only on the registered count, never on KBD_VALID or a same-cycle pop.
  assign push       = KBD_VALID & ~fifo_full;
  assign pop        = LD_MDR & (INMUX_SEL == 2'b00) & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: empty FIFO contents are never observed.
  always_ff @(posedge i_Clk) begin
    if (push) fifo_q[wr_ptr_q] <= KBD_DATA;
  end

  always_comb begin
    kbsr_ie_d = LD_KBSR ? MDR_OUT[14] : kbsr_ie_q;
    dsr_ie_d  = LD_DSR  ? MDR_OUT[14] : dsr_ie_q;
  end

  // Display handshake: a DDR write is taken only while the registered ready bit is set.
  always_comb begin
    state_d      = state_q;
    ddr_d        = ddr_q;
    dsr_rdy_d    = dsr_rdy_q;
    dly_cnt_d    = dly_cnt_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (LD_DDR && dsr_rdy_q) begin
          ddr_d        = MDR_OUT;
          dsr_rdy_d    = 1'b0;
          disp_valid_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (DISP_READY) begin
          disp_valid_d = 1'b0;
          if (DISP_DELAY == 0) begin
            dsr_rdy_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            dly_cnt_d = DLY_W'(DISP_DELAY);
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_cnt_q <= DLY_W'(1)) begin
          dly_cnt_d = '0;
          dsr_rdy_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_W'(1);
        end
      end
      default: begin
        disp_valid_d = 1'b0;
        dsr_rdy_d    = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      kbsr_ie_q    <= 1'b0;
      dsr_ie_q     <= 1'b0;
      dsr_rdy_q    <= 1'b1;
      ddr_q        <= '0;
      dly_cnt_q    <= '0;
      disp_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      kbsr_ie_q    <= kbsr_ie_d;
      dsr_ie_q     <= dsr_ie_d;
      dsr_rdy_q    <= dsr_rdy_d;
      ddr_q        <= ddr_d;
      dly_cnt_q    <= dly_cnt_d;
      disp_valid_q <= disp_valid_d;
      state_q      <= state_d;
    end
  end

  assign kbdr = fifo_empty ? 16'h0000 : {8'h00, fifo_q[rd_ptr_q]};
  assign kbsr = {~fifo_empty, kbsr_ie_q, 14'b0};
  assign dsr  = {dsr_rdy_q, dsr_ie_q, 14'b0};

  always_comb begin
    case (INMUX_SEL)
      2'b00:   IN_MUX_OUT = kbdr;
      2'b01:   IN_MUX_OUT = kbsr;
      2'b10:   IN_MUX_OUT = dsr;
      default: IN_MUX_OUT = MEM_OUT;
    endcase
  end

  assign KBD_READY  = ~fifo_full;
  assign DISP_VALID = disp_valid_q;
  assign DISP_DATA  = ddr_q[7:0];
  assign KB_INTR    = ~fifo_empty & kbsr_ie_q;
  assign DISP_INTR  = dsr_rdy_q & dsr_ie_q;

endmodule

// File: tb/tb_io_device_regs.sv
// Bench for io_device_regs: directed scenarios plus random traffic, all
// checked against a queue/cycle-count reference model.
module tb_io_device_regs;

  localparam int DEPTH = 4;
  localparam int DELAY = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mdr_out = '0, mem_out = '0;
  logic        ld_kbsr = 0, ld_ddr = 0, ld_dsr = 0, ld_mdr = 0;
  logic [1:0]  sel = '0;
  logic        kbd_valid = 0, disp_ready = 0;
  logic [7:0]  kbd_data = '0;
  logic        kbd_ready, disp_valid, kb_intr, disp_intr;
  logic [7:0]  disp_data;
  logic [15:0] mux_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] kq[$];
  logic       m_kbsr14, m_dsr14, m_ready, m_sending;
  logic [7:0] m_ddr;
  int         ready_at;

  io_device_regs #(.KBD_DEPTH(DEPTH), .DISP_DELAY(DELAY)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .MDR_OUT(mdr_out), .LD_KBSR(ld_kbsr),
    .LD_DDR(ld_ddr), .LD_DSR(ld_dsr), .INMUX_SEL(sel), .LD_MDR(ld_mdr),
    .MEM_OUT(mem_out), .KBD_VALID(kbd_valid), .KBD_DATA(kbd_data),
    .KBD_READY(kbd_ready), .DISP_VALID(disp_valid), .DISP_DATA(disp_data),
    .DISP_READY(disp_ready), .IN_MUX_OUT(mux_out), .KB_INTR(kb_intr),
    .DISP_INTR(disp_intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    m_kbsr14 = 0; m_dsr14 = 0; m_ready = 1; m_sending = 0; m_ddr = '0; ready_at = 0;
  endtask

  function automatic logic [15:0] exp_mux();
    case (sel)
      2'b00:   return (kq.size() > 0) ? {8'h00, kq[0]} : 16'h0000;
      2'b01:   return {kq.size() > 0, m_kbsr14, 14'b0};
      2'b10:   return {m_ready, m_dsr14, 14'b0};
      default: return mem_out;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".kbd_ready"}, 16'(kbd_ready), 16'(kq.size() < DEPTH));
    chk({tag, ".disp_valid"}, 16'(disp_valid), 16'(m_sending));
    if (m_sending) chk({tag, ".disp_data"}, 16'(disp_data), 16'(m_ddr));
    chk({tag, ".mux"}, mux_out, exp_mux());
    chk({tag, ".kb_intr"}, 16'(kb_intr), 16'((kq.size() > 0) && m_kbsr14));
    chk({tag, ".disp_intr"}, 16'(disp_intr), 16'(m_ready && m_dsr14));
  endtask

  // One clock: model evaluated on pre-edge inputs, strobes dropped, outputs checked.
  task automatic tick(input string tag);
    bit push, pop;
    push = kbd_valid && (kq.size() < DEPTH);
    pop  = ld_mdr && (sel == 2'b00) && (kq.size() > 0);
    @(posedge clk);
    cyc++;
    if (pop)  void'(kq.pop_front());
    if (push) kq.push_back(kbd_data);
    if (ld_kbsr) m_kbsr14 = mdr_out[14];
    if (ld_dsr)  m_dsr14  = mdr_out[14];
    if (m_sending && disp_ready) begin
      m_sending = 0;
      ready_at  = cyc + DELAY;
    end else if (ld_ddr && m_ready) begin
      m_ready = 0; m_sending = 1; m_ddr = mdr_out[7:0];
    end
    if (!m_ready && !m_sending && cyc >= ready_at) m_ready = 1;
    #1;
    ld_kbsr = 0; ld_ddr = 0; ld_dsr = 0; ld_mdr = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    #12;
    chk("rst.kbd_ready", 16'(kbd_ready), 16'h1);
    chk("rst.disp_valid", 16'(disp_valid), 16'h0);
    chk("rst.disp_data", 16'(disp_data), 16'h0);
    chk("rst.kb_intr", 16'(kb_intr), 16'h0);
    chk("rst.disp_intr", 16'(disp_intr), 16'h0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Reset register values
    sel = 2'b10; #1; chk("reset.dsr", mux_out, 16'h8000);
    sel = 2'b01; #1; chk("reset.kbsr", mux_out, 16'h0000);
    chk("reset.kbd_ready", 16'(kbd_ready), 16'h1);

    // Two pushes, two pops, one ignored pop on empty
    kbd_valid = 1; kbd_data = 8'h41; tick("push41");
    kbd_data = 8'h42; tick("push42");
    kbd_valid = 0;
    chk("kbsr.nonempty", mux_out, 16'h8000);
    sel = 2'b00; #1; chk("kbdr.41", mux_out, 16'h0041);
    ld_mdr = 1; tick("pop41");
    chk("kbdr.42", mux_out, 16'h0042);
    ld_mdr = 1; tick("pop42");
    sel = 2'b01; #1; chk("kbsr.empty", mux_out, 16'h0000);
    sel = 2'b00; ld_mdr = 1; tick("pop_empty");
    chk("kbdr.empty", mux_out, 16'h0000);

    // Fill to full across the pointer wrap, pop+offer on full
    kbd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      kbd_data = 8'h10 + 8'(i); tick("fill");
    end
    chk("full.kbd_ready", 16'(kbd_ready), 16'h0);
    kbd_data = 8'h14; tick("full_hold");
    chk("full.held", 16'(kbd_ready), 16'h0);
    ld_mdr = 1; tick("pop_offer");
    chk("after_pop.kbd_ready", 16'(kbd_ready), 16'h1);
    tick("accept5");
    kbd_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("wrap_order", mux_out, {8'h00, 8'h10 + 8'(i)});
      ld_mdr = 1; tick("drain");
    end
    chk("drained", mux_out, 16'h0000);

    // Display transfer with stall, dropped second write, delayed ready
    sel = 2'b10; disp_ready = 0;
    mdr_out = 16'h0058; ld_ddr = 1; tick("ddr58");
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mdr_out = 16'h0059; ld_ddr = 1; end
      tick("stall");
      chk("stall.valid", 16'(disp_valid), 16'h1);
      chk("stall.data", 16'(disp_data), 16'h0058);
      chk("stall.dsr", mux_out, 16'h0000);
    end
    disp_ready = 1; tick("accept");
    disp_ready = 0;
    chk("accept.dsr", mux_out, 16'h0000);
    tick("wait1");
    chk("wait1.dsr", mux_out, 16'h0000);
    tick("wait2");
    chk("ready.dsr", mux_out, 16'h8000);

    // Interrupt enables
    sel = 2'b01; mdr_out = 16'hFFFF; ld_kbsr = 1; tick("kbsr_ie");
    chk("kbsr.ie", mux_out, 16'h4000);
    chk("kb_intr.off", 16'(kb_intr), 16'h0);
    kbd_valid = 1; kbd_data = 8'h33; tick("push_intr");
    kbd_valid = 0;
    chk("kb_intr.on", 16'(kb_intr), 16'h1);
    chk("kbsr.c000", mux_out, 16'hC000);
    mdr_out = 16'h4000; ld_dsr = 1; tick("dsr_ie");
    chk("disp_intr.on", 16'(disp_intr), 16'h1);
    mdr_out = 16'h0000; ld_kbsr = 1; ld_dsr = 1; tick("ie_clear");

    // Async reset mid-transfer with two queued bytes
    kbd_valid = 1; kbd_data = 8'h61; tick("rpush");
    kbd_data = 8'h62; kbd_valid = 1;
    mdr_out = 16'h0077; ld_ddr = 1; tick("rsend");
    kbd_valid = 0;
    chk("pre_rst.valid", 16'(disp_valid), 16'h1);
    #2; rst_n = 0; #1;
    model_reset();
    chk("async.disp_valid", 16'(disp_valid), 16'h0);
    chk("async.kbd_ready", 16'(kbd_ready), 16'h1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    sel = 2'b10; #1; chk("post_rst.dsr", mux_out, 16'h8000);
    sel = 2'b00; #1; chk("post_rst.kbdr", mux_out, 16'h0000);
    sel = 2'b01; #1; chk("post_rst.kbsr", mux_out, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      kbd_valid  = ($urandom_range(0, 1) == 1);
      kbd_data   = 8'($urandom);
      sel        = 2'($urandom);
      ld_mdr     = ($urandom_range(0, 2) == 0);
      ld_ddr     = ($urandom_range(0, 3) == 0);
      disp_ready = ($urandom_range(0, 1) == 1);
      ld_kbsr    = ($urandom_range(0, 15) == 0);
      ld_dsr     = ($urandom_range(0, 15) == 0);
      mdr_out    = 16'($urandom);
      mem_out    = 16'($urandom);
      #1;
      chk("rand.pre_mux", mux_out, exp_mux());
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
